// File: rtl/uart_transmitter.sv
// 8-bit UART transmitter: valid/ready byte in, LSB-first serial frame out
// on tx (start, 8 data, optional even parity, STOP_BITS stop bits).
//
// Parameters: CLKS_PER_BIT (1..65535), STOP_BITS (1 or 2)
// Ports:
//   clk   in   system clock, posedge
//   rst   in   async active-low reset
//   data  in   [7:0] byte, sampled on acceptance only
//   valid in   byte offered
//   ready out  idle, can accept (registered)
//   tx    out  serial line, idles high (registered)
//   busy  out  frame in progress, complement of ready (registered)
// Optional: define UART_TX_PARITY_EN to add an even-parity bit after data.
module uart_transmitter #(
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       tx,
  output logic       busy
);

  localparam int CW_RAW = $clog2(CLKS_PER_BIT + 1);
  localparam int CW     = (CW_RAW < 1) ? 1 : CW_RAW;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic SB_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_idx;
  logic          r_sbit;
  logic [7:0]    r_data;
  logic          r_tx;
  logic          r_ready;
  logic          r_busy;

  logic          w_last;
  logic [2:0]    w_nidx;

  assign w_last = (r_cnt == LAST);
  assign w_nidx = r_idx + 3'd1;

  assign ready = r_ready;
  assign busy  = r_busy;
  assign tx    = r_tx;

  // tx is updated together with the state so the line changes exactly
  // on the bit boundary and stays glitch-free.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_sbit  <= 1'b0;
      r_data  <= '0;
      r_tx    <= 1'b1;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (valid) begin
            r_data  <= data;
            r_state <= START;
            r_tx    <= 1'b0;
            r_cnt   <= '0;
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
        START: begin
          if (w_last) begin
            r_cnt   <= '0;
            r_idx   <= '0;
            r_state <= DATA;
            r_tx    <= r_data[0];
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        DATA: begin
          if (w_last) begin
            r_cnt <= '0;
            if (r_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              r_state <= PARITY;
              r_tx    <= ^r_data;
`else
              r_state <= STOP;
              r_tx    <= 1'b1;
              r_sbit  <= 1'b0;
`endif
            end else begin
              r_idx <= w_nidx;
              r_tx  <= r_data[w_nidx];
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (w_last) begin
            r_cnt   <= '0;
            r_state <= STOP;
            r_tx    <= 1'b1;
            r_sbit  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
`endif
        STOP: begin
          if (w_last) begin
            r_cnt <= '0;
            if (r_sbit == SB_LAST) begin
              r_state <= IDLE;
              r_ready <= 1'b1;
              r_busy  <= 1'b0;
            end else begin
              r_sbit <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: begin
          r_state <= IDLE;
          r_tx    <= 1'b1;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter: two instances
// (CLKS_PER_BIT=4/STOP_BITS=1 and CLKS_PER_BIT=1/STOP_BITS=2).
module tb_uart_transmitter;

  logic       clk;
  logic       rst;
  logic [7:0] data;
  logic       valid1, valid2;
  logic       ready1, ready2;
  logic       tx1, tx2;
  logic       busy1, busy2;

  int total = 0;
  int bad   = 0;

  uart_transmitter #(.CLKS_PER_BIT(4), .STOP_BITS(1)) u_dut (
    .clk(clk), .rst(rst), .data(data), .valid(valid1),
    .ready(ready1), .tx(tx1), .busy(busy1)
  );

  uart_transmitter #(.CLKS_PER_BIT(1), .STOP_BITS(2)) u_dut2 (
    .clk(clk), .rst(rst), .data(data), .valid(valid2),
    .ready(ready2), .tx(tx2), .busy(busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs,
                     input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b at %0t",
             tag, obs, exp, $time);
    end
  endtask

  task automatic chk_idle(input int sel, input string tag);
    chk({tag, ".tx"},    sel != 0 ? tx2 : tx1, 1'b1);
    chk({tag, ".ready"}, sel != 0 ? ready2 : ready1, 1'b1);
    chk({tag, ".busy"},  sel != 0 ? busy2 : busy1, 1'b0);
  endtask

  // Offer byte b (DUT must be idle), then check the whole frame cycle
  // by cycle. data is switched to nxt right after acceptance; if hold
  // is set, valid stays high so the next frame follows back-to-back.
  task automatic run_frame(input int sel, input logic [7:0] b,
                           input logic hold, input logic [7:0] nxt,
                           input string tag);
    logic e [12];
    int   nb;
    int   cpb;
    int   nstop;
    cpb   = (sel != 0) ? 1 : 4;
    nstop = (sel != 0) ? 2 : 1;
    nb    = 0;
    e[nb] = 1'b0;
    nb++;
    for (int i = 0; i < 8; i++) begin
      e[nb] = b[i];
      nb++;
    end
`ifdef UART_TX_PARITY_EN
    e[nb] = ^b;
    nb++;
`endif
    for (int s = 0; s < nstop; s++) begin
      e[nb] = 1'b1;
      nb++;
    end
    data = b;
    if (sel != 0) valid2 = 1'b1;
    else valid1 = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) begin
      valid1 = 1'b0;
      valid2 = 1'b0;
    end
    data = nxt;
    for (int i = 0; i < nb; i++) begin
      for (int j = 0; j < cpb; j++) begin
        chk({tag, ".tx"},    sel != 0 ? tx2 : tx1, e[i]);
        chk({tag, ".busy"},  sel != 0 ? busy2 : busy1, 1'b1);
        chk({tag, ".ready"}, sel != 0 ? ready2 : ready1, 1'b0);
        @(posedge clk);
        #1;
      end
    end
    chk_idle(sel, {tag, ".end"});
  endtask

  initial begin
    rst    = 1'b0;
    data   = 8'hA5;
    valid1 = 1'b1;
    valid2 = 1'b0;

    // reset held with valid high: nothing accepted
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      chk_idle(0, "rst1");
      chk_idle(1, "rst2");
    end
    rst = 1'b1;
    #1;
    chk_idle(0, "rel");

    // single frame 0xA5, accepted on first edge after release
    run_frame(0, 8'hA5, 1'b0, 8'h33, "a5");

    // back-to-back 0x00 then 0xFF; data flips during frame 1
    run_frame(0, 8'h00, 1'b1, 8'hFF, "b2b0");
    run_frame(0, 8'hFF, 1'b0, 8'h00, "b2b1");

    // two stop bits at one clock per bit
    run_frame(1, 8'h3C, 1'b0, 8'hC3, "s2");

    // mid-frame reset during data bit 3 of 0x0F
    data   = 8'h0F;
    valid1 = 1'b1;
    @(posedge clk);
    #1;
    valid1 = 1'b0;
    data   = 8'h00;
    repeat (17) begin
      @(posedge clk);
      #1;
    end
    chk("mid.busy", busy1, 1'b1);
    rst = 1'b0;
    #1;
    chk_idle(0, "mid.async");
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk_idle(0, "mid.rel");
    run_frame(0, 8'h55, 1'b0, 8'hAA, "after");

    // parity values (exercise the optional bit when built with it)
    run_frame(0, 8'h01, 1'b0, 8'hFE, "p01");
    run_frame(0, 8'hA5, 1'b0, 8'h5A, "pa5");

    repeat (3) begin
      @(posedge clk);
      #1;
      chk_idle(0, "quiet1");
      chk_idle(1, "quiet2");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
